// File: rtl/fp_mult_arbiter_if.sv
// fp_mult_arbiter_if: requester request/response channels plus the core's AXI-stream channels
interface fp_mult_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
    logic [DATA_W-1:0]         rsp_data;
    logic                      m_axis_a_tvalid, m_axis_a_tready;
    logic [DATA_W-1:0]         m_axis_a_tdata;
    logic                      m_axis_b_tvalid, m_axis_b_tready;
    logic [DATA_W-1:0]         m_axis_b_tdata;
    logic                      s_axis_result_tvalid, s_axis_result_tready;
    logic [DATA_W-1:0]         s_axis_result_tdata;
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        input  m_axis_a_tready, m_axis_b_tready, s_axis_result_tvalid, s_axis_result_tdata,
        output req_ready, rsp_valid, rsp_data,
        output m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata, s_axis_result_tready
    );
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        output m_axis_a_tready, m_axis_b_tready, s_axis_result_tvalid, s_axis_result_tdata,
        input  req_ready, rsp_valid, rsp_data,
        input  m_axis_a_tvalid, m_axis_a_tdata, m_axis_b_tvalid, m_axis_b_tdata, s_axis_result_tready
    );
endinterface

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin sharing of one fp multiplier core among NUM_REQ requesters,
// with an in-order tag FIFO steering each result back to the requester that issued it
module fp_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    fp_mult_arbiter_if.slave         bus,
    output logic [$clog2(MAX_OUT):0] o_outstanding,
    output logic                     o_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam logic [0:0] IDLE = 1'b0, ISSUE = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] grant, last, pick, idx, head;
    logic          found, a_done, b_done, a_fin, b_fin, issue_done, full, empty, pop;
    logic [IW-1:0] tags [MAX_OUT];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // first valid requester after the last grant, wrapping
    always_comb begin
        pick = last;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick = idx;
            end
        end
    end

    // a handshake in the current cycle already counts toward completion
    assign a_fin      = a_done | (bus.m_axis_a_tvalid & bus.m_axis_a_tready);
    assign b_fin      = b_done | (bus.m_axis_b_tvalid & bus.m_axis_b_tready);
    assign issue_done = (state == ISSUE) & a_fin & b_fin;
    assign empty      = o_outstanding == '0;
    assign full       = o_outstanding == (PW+1)'(MAX_OUT);
    assign head       = tags[rd_ptr];
    assign pop        = bus.s_axis_result_tvalid & bus.s_axis_result_tready & ~empty;
    assign bus.rsp_data = bus.s_axis_result_tdata;

    // with no tag outstanding a result is stray: drain it and route it nowhere
    always_comb begin
        bus.req_ready = issue_done ? NUM_REQ'(1) << grant : '0;
        bus.rsp_valid = (bus.s_axis_result_tvalid && !empty) ? NUM_REQ'(1) << head : '0;
        bus.s_axis_result_tready = empty ? 1'b1 : bus.rsp_ready[head];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            grant <= '0;
            last <= IW'(NUM_REQ - 1);
            a_done <= 1'b0;
            b_done <= 1'b0;
            bus.m_axis_a_tvalid <= 1'b0;
            bus.m_axis_b_tvalid <= 1'b0;
            bus.m_axis_a_tdata <= '0;
            bus.m_axis_b_tdata <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            o_outstanding <= '0;
            o_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (found && !full) begin
                    grant <= pick;
                    bus.m_axis_a_tdata <= bus.req_a[pick*DATA_W +: DATA_W];
                    bus.m_axis_b_tdata <= bus.req_b[pick*DATA_W +: DATA_W];
                    bus.m_axis_a_tvalid <= 1'b1;
                    bus.m_axis_b_tvalid <= 1'b1;
                    a_done <= 1'b0;
                    b_done <= 1'b0;
                    state <= ISSUE;
                end
            end else begin
                if (bus.m_axis_a_tvalid && bus.m_axis_a_tready) begin
                    bus.m_axis_a_tvalid <= 1'b0;
                    a_done <= 1'b1;
                end
                if (bus.m_axis_b_tvalid && bus.m_axis_b_tready) begin
                    bus.m_axis_b_tvalid <= 1'b0;
                    b_done <= 1'b1;
                end
                if (issue_done) begin
                    last <= grant;
                    state <= IDLE;
                end
            end
            if (issue_done)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (issue_done != pop)
                o_outstanding <= issue_done ? o_outstanding + 1'b1 : o_outstanding - 1'b1;
            if (bus.s_axis_result_tvalid && empty)
                o_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk)
        if (issue_done)
            tags[wr_ptr] <= grant;
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: randomized bench with a queue-based multiplier core model and a
// round-robin grant-order reference computed from pending request counts
module tb_fp_mult_arbiter;
    localparam int NUM_REQ = 4, DATA_W = 32, MAX_OUT = 8, DEPTH = 64;

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] o_outstanding;
    logic o_err;
    int tests = 0, fails = 0;

    fp_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();
    fp_mult_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus), .o_outstanding(o_outstanding), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int target [NUM_REQ];
    int granted [NUM_REQ];
    int mdl_cnt [NUM_REQ];
    logic [DATA_W-1:0] ops_a [NUM_REQ][DEPTH];
    logic [DATA_W-1:0] ops_b [NUM_REQ][DEPTH];
    logic a_rdy = 1'b1, b_rdy = 1'b1, stray = 1'b0, res_v = 1'b0;
    logic [NUM_REQ-1:0] rsp_rdy = '1;
    logic [DATA_W-1:0] stray_d = '0, res_d = '0;
    int ref_last = NUM_REQ - 1, max_out = 0, multi_rsp = 0;
    logic [DATA_W-1:0] qa [$], qb [$], rq [$];
    int grant_log [$], rsp_id [$];
    logic [DATA_W-1:0] rsp_dat [$];

    // truncating single-precision multiply, normal operands only
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int e;
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            m = m >> 1;
            e++;
        end
        return {a[31] ^ b[31], 8'(e), m[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i] = target[i] != granted[i];
            bus.req_a[i*DATA_W +: DATA_W] = ops_a[i][granted[i] % DEPTH];
            bus.req_b[i*DATA_W +: DATA_W] = ops_b[i][granted[i] % DEPTH];
        end
    end

    assign bus.m_axis_a_tready = a_rdy;
    assign bus.m_axis_b_tready = b_rdy;
    assign bus.rsp_ready = rsp_rdy;
    assign bus.s_axis_result_tvalid = res_v | stray;
    assign bus.s_axis_result_tdata = stray ? stray_d : res_d;

    // core model: pairs A/B beats in arrival order and returns products in order
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            rq.delete();
            res_v <= 1'b0;
        end else begin
            if (bus.m_axis_a_tvalid && bus.m_axis_a_tready) qa.push_back(bus.m_axis_a_tdata);
            if (bus.m_axis_b_tvalid && bus.m_axis_b_tready) qb.push_back(bus.m_axis_b_tdata);
            if (res_v && bus.s_axis_result_tready) void'(rq.pop_front());
            while (qa.size() > 0 && qb.size() > 0) rq.push_back(fmul(qa.pop_front(), qb.pop_front()));
            res_v <= rq.size() > 0;
            res_d <= rq.size() > 0 ? rq[0] : '0;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i]) begin
                    granted[i] <= granted[i] + 1;
                    grant_log.push_back(i);
                end
                if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
                    rsp_id.push_back(i);
                    rsp_dat.push_back(bus.rsp_data);
                end
            end
            if ($countones(bus.rsp_valid) > 1) multi_rsp <= multi_rsp + 1;
            if (int'(o_outstanding) > max_out) max_out <= int'(o_outstanding);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input int i, input logic [31:0] a, input logic [31:0] b);
        ops_a[i][target[i] % DEPTH] = a;
        ops_b[i][target[i] % DEPTH] = b;
        target[i]++;
    endtask

    task automatic predict(input int cnt [NUM_REQ], output int seq [$], output logic [31:0] want [$]);
        int p [NUM_REQ];
        int g;
        p = cnt;
        seq.delete();
        want.delete();
        for (int n = 0; n < 256; n++) begin
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++)
                if (g < 0 && p[(ref_last + k) % NUM_REQ] > 0) g = (ref_last + k) % NUM_REQ;
            if (g < 0) break;
            seq.push_back(g);
            want.push_back(fmul(ops_a[g][mdl_cnt[g] % DEPTH], ops_b[g][mdl_cnt[g] % DEPTH]));
            p[g]--;
            mdl_cnt[g]++;
            ref_last = g;
        end
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        int c = 0;
        while (rsp_id.size() < n && c < budget) begin
            step();
            c++;
        end
        ok = rsp_id.size() >= n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        tests++; if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b%b expected 00", bus.m_axis_a_tvalid, bus.m_axis_b_tvalid); end
        tests++; if (bus.req_ready !== '0) begin fails++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
        tests++; if (bus.rsp_valid !== '0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        tests++; if (o_err !== 1'b0 || o_outstanding !== 4'd0) begin fails++; $display("FAIL reset_status: got err=%b out=%0d expected 0/0", o_err, o_outstanding); end
        tests++; if (bus.m_axis_a_tdata !== '0 || bus.m_axis_b_tdata !== '0) begin fails++; $display("FAIL reset_tdata: got %h %h expected 0", bus.m_axis_a_tdata, bus.m_axis_b_tdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int c [NUM_REQ];
        int seq [$];
        logic [31:0] want [$];
        int g0 = grant_log.size(), r0 = rsp_id.size();
        bit ok;
        enqueue(1, 32'h40000000, 32'h40400000);
        c = '{0, 1, 0, 0};
        predict(c, seq, want);
        step();
        tests++; if (bus.m_axis_a_tvalid !== 1'b1 || bus.m_axis_b_tvalid !== 1'b1) begin fails++; $display("FAIL single_tvalid: got %b%b expected 11", bus.m_axis_a_tvalid, bus.m_axis_b_tvalid); end
        tests++; if (bus.req_ready !== 4'b0010) begin fails++; $display("FAIL single_req_ready: got %b expected 0010", bus.req_ready); end
        tests++; if (o_outstanding !== 4'd0) begin fails++; $display("FAIL single_out0: got %0d expected 0", o_outstanding); end
        step();
        tests++; if (o_outstanding !== 4'd1) begin fails++; $display("FAIL single_out1: got %0d expected 1", o_outstanding); end
        tests++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'h40C00000) begin fails++; $display("FAIL single_rsp: got %b/%h expected 0010/40c00000", bus.rsp_valid, bus.rsp_data); end
        wait_rsp(r0 + 1, 20, ok);
        step();
        tests++; if (!ok || rsp_id[r0] !== 1 || rsp_dat[r0] !== want[0]) begin fails++; $display("FAIL single_route: got ok=%b id=%0d expected id=1", ok, ok ? rsp_id[r0] : -1); end
        tests++; if (o_outstanding !== 4'd0 || grant_log.size() - g0 !== 1) begin fails++; $display("FAIL single_done: got out=%0d grants=%0d expected 0/1", o_outstanding, grant_log.size() - g0); end
    endtask

    task automatic test_round_robin();
        int c [NUM_REQ];
        int seq [$];
        logic [31:0] want [$];
        int g0, r0;
        bit ok;
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_last = NUM_REQ - 1;
        g0 = grant_log.size();
        r0 = rsp_id.size();
        c = '{2, 1, 1, 1};
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < c[i]; k++) enqueue(i, rnd_fp(), rnd_fp());
        predict(c, seq, want);
        wait_rsp(r0 + seq.size(), 100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rr_timeout: got %0d responses expected %0d", rsp_id.size() - r0, seq.size()); end
        for (int n = 0; n < seq.size(); n++) begin
            int gg = (g0 + n < grant_log.size()) ? grant_log[g0 + n] : -1;
            int ri = (r0 + n < rsp_id.size()) ? rsp_id[r0 + n] : -1;
            logic [31:0] rd = (r0 + n < rsp_dat.size()) ? rsp_dat[r0 + n] : 32'hx;
            tests++; if (gg !== seq[n]) begin fails++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", n, gg, seq[n]); end
            tests++; if (ri !== seq[n] || rd !== want[n]) begin fails++; $display("FAIL rr_rsp[%0d]: got %0d/%h expected %0d/%h", n, ri, rd, seq[n], want[n]); end
        end
    endtask

    task automatic test_split();
        int c [NUM_REQ];
        int seq [$];
        logic [31:0] want [$];
        int g0 = grant_log.size(), r0 = rsp_id.size();
        bit ok;
        a_rdy = 1'b1;
        b_rdy = 1'b0;
        enqueue(2, rnd_fp(), rnd_fp());
        c = '{0, 0, 1, 0};
        predict(c, seq, want);
        step();
        tests++; if (bus.m_axis_a_tvalid !== 1'b1 || bus.req_ready !== '0) begin fails++; $display("FAIL split_start: got a=%b ready=%b expected 1/0", bus.m_axis_a_tvalid, bus.req_ready); end
        for (int n = 0; n < 3; n++) begin
            step();
            tests++; if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b1 || bus.req_ready !== '0) begin fails++; $display("FAIL split_wait[%0d]: got a=%b b=%b ready=%b expected 0/1/0", n, bus.m_axis_a_tvalid, bus.m_axis_b_tvalid, bus.req_ready); end
        end
        b_rdy = 1'b1;
        #1;
        tests++; if (bus.req_ready !== 4'b0100) begin fails++; $display("FAIL split_ready: got %b expected 0100", bus.req_ready); end
        step();
        tests++; if (o_outstanding !== 4'd1) begin fails++; $display("FAIL split_out: got %0d expected 1", o_outstanding); end
        wait_rsp(r0 + 1, 20, ok);
        step();
        tests++; if (!ok || grant_log.size() - g0 !== 1 || rsp_id[r0] !== 2 || rsp_dat[r0] !== want[0]) begin fails++; $display("FAIL split_result: got ok=%b grants=%0d expected 1 grant to 2", ok, grant_log.size() - g0); end
    endtask

    task automatic test_full();
        int c [NUM_REQ];
        int seq [$];
        logic [31:0] want [$];
        int g0 = grant_log.size(), r0 = rsp_id.size();
        bit ok;
        rsp_rdy = '0;
        c = '{3, 3, 3, 3};
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < c[i]; k++) enqueue(i, rnd_fp(), rnd_fp());
        predict(c, seq, want);
        repeat (80) step();
        tests++; if (o_outstanding !== 4'd8 || grant_log.size() - g0 !== MAX_OUT) begin fails++; $display("FAIL full_count: got out=%0d grants=%0d expected 8/8", o_outstanding, grant_log.size() - g0); end
        tests++; if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0) begin fails++; $display("FAIL full_stall: got %b%b expected 00", bus.m_axis_a_tvalid, bus.m_axis_b_tvalid); end
        rsp_rdy = '1;
        wait_rsp(r0 + seq.size(), 200, ok);
        step();
        tests++; if (!ok || o_outstanding !== 4'd0) begin fails++; $display("FAIL full_drain: got ok=%b out=%0d expected 1/0", ok, o_outstanding); end
        tests++; if (max_out > MAX_OUT || multi_rsp !== 0) begin fails++; $display("FAIL full_bounds: got max=%0d multi=%0d expected <=8/0", max_out, multi_rsp); end
        for (int n = 0; n < seq.size(); n++) begin
            int gg = (g0 + n < grant_log.size()) ? grant_log[g0 + n] : -1;
            int ri = (r0 + n < rsp_id.size()) ? rsp_id[r0 + n] : -1;
            logic [31:0] rd = (r0 + n < rsp_dat.size()) ? rsp_dat[r0 + n] : 32'hx;
            tests++; if (gg !== seq[n] || ri !== seq[n] || rd !== want[n]) begin fails++; $display("FAIL full_order[%0d]: got %0d/%0d/%h expected %0d/%h", n, gg, ri, rd, seq[n], want[n]); end
        end
    endtask

    task automatic test_random();
        int c [NUM_REQ];
        int seq [$];
        logic [31:0] want [$];
        int g0, r0, cyc;
        for (int round = 0; round < 4; round++) begin
            g0 = grant_log.size();
            r0 = rsp_id.size();
            for (int i = 0; i < NUM_REQ; i++) begin
                c[i] = $urandom_range(0, 4);
                for (int k = 0; k < c[i]; k++) enqueue(i, rnd_fp(), rnd_fp());
            end
            predict(c, seq, want);
            cyc = 0;
            while (rsp_id.size() < r0 + seq.size() && cyc < 500) begin
                step();
                a_rdy = 1'($urandom);
                b_rdy = 1'($urandom);
                rsp_rdy = NUM_REQ'($urandom);
                cyc++;
            end
            a_rdy = 1'b1;
            b_rdy = 1'b1;
            rsp_rdy = '1;
            tests++; if (rsp_id.size() - r0 !== seq.size()) begin fails++; $display("FAIL rand_count[%0d]: got %0d expected %0d", round, rsp_id.size() - r0, seq.size()); end
            for (int n = 0; n < seq.size(); n++) begin
                int gg = (g0 + n < grant_log.size()) ? grant_log[g0 + n] : -1;
                int ri = (r0 + n < rsp_id.size()) ? rsp_id[r0 + n] : -1;
                logic [31:0] rd = (r0 + n < rsp_dat.size()) ? rsp_dat[r0 + n] : 32'hx;
                tests++; if (gg !== seq[n] || ri !== seq[n] || rd !== want[n]) begin fails++; $display("FAIL rand[%0d][%0d]: got %0d/%0d/%h expected %0d/%h", round, n, gg, ri, rd, seq[n], want[n]); end
            end
            step();
        end
    endtask

    task automatic test_stray();
        int r0 = rsp_id.size();
        tests++; if (o_outstanding !== 4'd0 || o_err !== 1'b0) begin fails++; $display("FAIL stray_pre: got out=%0d err=%b expected 0/0", o_outstanding, o_err); end
        stray_d = $urandom;
        stray = 1'b1;
        #1;
        tests++; if (bus.s_axis_result_tready !== 1'b1 || bus.rsp_valid !== '0) begin fails++; $display("FAIL stray_drain: got tready=%b rsp_valid=%b expected 1/0", bus.s_axis_result_tready, bus.rsp_valid); end
        step();
        stray = 1'b0;
        tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL stray_err: got %b expected 1", o_err); end
        repeat (5) step();
        tests++; if (o_err !== 1'b1 || rsp_id.size() !== r0) begin fails++; $display("FAIL stray_sticky: got err=%b rsps=%0d expected 1/0", o_err, rsp_id.size() - r0); end
    endtask

    task automatic test_reset_mid();
        int c [NUM_REQ];
        int seq [$];
        logic [31:0] want [$];
        int g0, r0;
        bit ok;
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        enqueue(3, rnd_fp(), rnd_fp());
        step();
        step();
        tests++; if (bus.m_axis_a_tvalid !== 1'b1) begin fails++; $display("FAIL rstmid_issue: got %b expected 1", bus.m_axis_a_tvalid); end
        enqueue(0, rnd_fp(), rnd_fp());
        rst = 1'b1;
        #1;
        tests++; if (bus.m_axis_a_tvalid !== 1'b0 || bus.m_axis_b_tvalid !== 1'b0 || bus.req_ready !== '0) begin fails++; $display("FAIL rstmid_outputs: got %b%b ready=%b expected 00/0", bus.m_axis_a_tvalid, bus.m_axis_b_tvalid, bus.req_ready); end
        tests++; if (o_err !== 1'b0 || o_outstanding !== 4'd0) begin fails++; $display("FAIL rstmid_status: got err=%b out=%0d expected 0/0", o_err, o_outstanding); end
        step();
        rst = 1'b0;
        ref_last = NUM_REQ - 1;
        g0 = grant_log.size();
        r0 = rsp_id.size();
        a_rdy = 1'b1;
        b_rdy = 1'b1;
        c = '{1, 0, 0, 1};
        predict(c, seq, want);
        wait_rsp(r0 + seq.size(), 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rstmid_timeout: got %0d responses expected %0d", rsp_id.size() - r0, seq.size()); end
        for (int n = 0; n < seq.size(); n++) begin
            int gg = (g0 + n < grant_log.size()) ? grant_log[g0 + n] : -1;
            int ri = (r0 + n < rsp_id.size()) ? rsp_id[r0 + n] : -1;
            logic [31:0] rd = (r0 + n < rsp_dat.size()) ? rsp_dat[r0 + n] : 32'hx;
            tests++; if (gg !== seq[n] || ri !== seq[n] || rd !== want[n]) begin fails++; $display("FAIL rstmid_order[%0d]: got %0d/%0d/%h expected %0d/%h", n, gg, ri, rd, seq[n], want[n]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_full();
        test_random();
        test_stray();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Round-robin arbiter and sequencer that shares one `fp_mult_sig` single-precision multiplier core among `NUM_REQ` requesters. Each requester presents an operand pair on its own valid/ready request channel. The block issues the pair to the core's `a` and `b` AXI-stream slave channels and records the requester ID in an in-order tag FIFO. It then routes each core result back to the requester that issued it. It sits between the requesters and the core, and drives the core's slave channels directly.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 32, operand/result width
- `MAX_OUT`, 8, tag FIFO depth and maximum in-flight operations (power of 2)

- `i_clk` in 1 — single clock
- `i_rst` in 1 — asynchronous, active-high reset
- `req_valid` in NUM_REQ — per-requester operand pair valid
- `req_ready` out NUM_REQ — per-requester operand pair consumed
- `req_a` in NUM_REQ*DATA_W — operand A; requester i occupies bits [i*DATA_W +: DATA_W]
- `req_b` in NUM_REQ*DATA_W — operand B, same packing as `req_a`
- `rsp_valid` out NUM_REQ — per-requester result valid
- `rsp_ready` in NUM_REQ — per-requester result accept
- `rsp_data` out DATA_W — result, shared by all requesters and qualified by `rsp_valid`
- `m_axis_a_tvalid`/`m_axis_a_tready`/`m_axis_a_tdata` out/in/out 1/1/DATA_W — to core `s_axis_a_*`
- `m_axis_b_tvalid`/`m_axis_b_tready`/`m_axis_b_tdata` out/in/out 1/1/DATA_W — to core `s_axis_b_*`
- `s_axis_result_tvalid`/`s_axis_result_tready`/`s_axis_result_tdata` in/out/in 1/1/DATA_W — from core `m_axis_result_*`
- `o_outstanding` out $clog2(MAX_OUT)+1 — count of operations issued but not yet returned
- `o_err` out 1 — sticky flag; set by a result that arrives while no operation is outstanding

## Operation
- State machine:
  - **IDLE:**
    - If any `req_valid` is high and the tag FIFO is not full, register the grant G. G is the first requester with `req_valid` high, searching from (last grant + 1) mod NUM_REQ.
    - Register G's operands into `m_axis_a_tdata`/`m_axis_b_tdata`.
    - Set both tvalids and clear flags `a_done`/`b_done`.
    - Go to ISSUE.
  - **ISSUE:**
    - Each channel drops its tvalid on its own handshake and sets its done flag.
    - The issue completes in the cycle where both channels are done. The current cycle's handshake counts toward completion.
    - On completion: pulse `req_ready[G]` combinationally for that cycle, push G into the tag FIFO, update the last-grant pointer to G, and return to IDLE.
- G is locked for the whole ISSUE state. A requester that drops `req_valid` during ISSUE is a protocol violation and is not handled.
- Response routing:
  - `rsp_valid[i]` = `s_axis_result_tvalid` AND FIFO not empty AND head tag == i.
  - `rsp_data` = `s_axis_result_tdata`.
  - `s_axis_result_tready` = `rsp_ready[head]` when the FIFO is not empty.
  - The FIFO pops on the result handshake.
- Stray result (tvalid high while the FIFO is empty):
  - Drive `s_axis_result_tready` = 1 to drain it.
  - Assert no `rsp_valid`.
  - Set `o_err`. It clears only on reset.
- `o_outstanding` tracks pushes and pops:
  - +1 on push only; −1 on pop only.
  - Unchanged when a push and a pop happen in the same cycle.
  - Never exceeds MAX_OUT. When full, IDLE does not grant.
- FIFO pointers are $clog2(MAX_OUT) bits wide and wrap naturally. Full/empty is derived from `o_outstanding`.

## Timing
- Reset values:
  - All tvalids, `req_ready`, `rsp_valid`, `o_err` = 0; `o_outstanding` = 0.
  - State = IDLE.
  - Last-grant pointer = NUM_REQ−1, so requester 0 has first priority.
  - FIFO empty; data registers 0.
- Asserting `i_rst` mid-operation aborts any issue in progress and discards all tags. Results the core returns afterwards are treated as stray and set `o_err`.
- Latency and throughput:
  - `req_valid` high in cycle N (block in IDLE) → tvalids high in N+1.
  - Earliest `req_ready` is in N+1, when the core accepts both channels immediately.
  - Peak issue rate is one operation per 2 cycles.
- Response path:
  - Purely combinational: zero added latency.
  - Results return in issue order, because the core preserves order.
- Fairness: a continuously requesting requester waits at most NUM_REQ−1 grants.

## Test plan
- **Single operation:** requester 1 sends a=0x40000000 (2.0), b=0x40400000 (3.0) → `req_ready[1]` pulses; `rsp_valid[1]` with `rsp_data`=0x40C00000 (6.0); no other `rsp_valid`; `o_outstanding` 0→1→0.
- **Round-robin:** all 4 requesters hold `req_valid` high with distinct operands → grants in order 0,1,2,3,0; each result appears on the matching `rsp_valid` in that order.
- **Split acceptance:** core holds `m_axis_b_tready` low for 3 cycles while `a_tready` is high → A handshakes once; `a_tvalid` then drops; `req_ready` waits for B; exactly one tag is pushed.
- **Backpressure and full:** `rsp_ready`=0 with MAX_OUT=8 and requests continuous → `o_outstanding` reaches 8 and no further tvalid is issued; releasing `rsp_ready` drains 8 results in order and issuing resumes.
- **Stray result:** with FIFO empty, pulse `s_axis_result_tvalid` → `s_axis_result_tready`=1, all `rsp_valid` stay 0, `o_err`=1 and stays set.
- **Reset mid-ISSUE:** assert `i_rst` while `a_tvalid`=1 → all outputs return to reset values immediately; after release, requester 0 is granted first.
